pc_fetch_unit: RTL and testbench

- Owns the program counter and the fetch sequence for the processor.
- Computes both candidate next-PC values (PC+4 and the PC+offset branch/jump target).
- Drives the select that chooses between them and registers the chosen value.
- Sequences one instruction at a time through a fetch/execute handshake with instruction memory, honouring data-memory stalls.

---
 rtl/pc_fetch_unit.sv | 85 ++++++++
 tb/tb_pc_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and single-issue fetch/execute sequencer.
// Holds each fetched instruction through EXEC and advances PC to PC+4 or to the branch/jump target.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        INSTR_READ,
  input  logic        INSTR_READY,
  input  logic [31:0] INSTR_IN,
  output logic [31:0] INSTRUCTION,
  input  logic        JUMP,
  input  logic        BRANCH_EQ,
  input  logic        BRANCH_NE,
  input  logic        ZERO,
  input  logic signed [7:0] OFFSET,
  input  logic        DATA_BUSYWAIT,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic [31:0] PC_TARGET,
  output logic        PC_SEL,
  output logic [31:0] RETIRED
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic        taken;
  logic        exec_done;

  // Instruction-count offset scaled to bytes: sign-extend, then times four.
  function automatic logic signed [31:0] offset_bytes(input logic signed [7:0] off);
    return {{22{off[7]}}, off, 2'b00};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (INSTR_READY) state_nxt = EXEC;
      EXEC:    if (!DATA_BUSYWAIT) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PC_PLUS4   = pc_q + PC_STEP;
    PC_TARGET  = PC_PLUS4 + $unsigned(offset_bytes(OFFSET));
    taken      = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
    PC_SEL     = (state == EXEC) & taken;
    INSTR_READ = (state == FETCH);
    exec_done  = (state == EXEC) & ~DATA_BUSYWAIT;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == FETCH) && INSTR_READY)
        instr_q <= INSTR_IN;
      // Decoder inputs only matter on the edge that leaves EXEC.
      if (exec_done) begin
        pc_q      <= PC_SEL ? PC_TARGET : PC_PLUS4;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign RETIRED     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random instruction streams,
// checked against an instruction-level model of PC, retired count and held instruction.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        INSTR_READY;
  logic [31:0] INSTR_IN;
  logic        JUMP, BRANCH_EQ, BRANCH_NE, ZERO;
  logic [7:0]  OFFSET;
  logic        DATA_BUSYWAIT;

  logic        INSTR_READ, PC_SEL;
  logic [31:0] INSTRUCTION, PC, PC_PLUS4, PC_TARGET, RETIRED;

  logic        w2_read, w2_sel;
  logic [31:0] w2_instr, w2_pc, w2_plus4, w2_target, w2_retired;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] m_pc, m_ret, m_instr;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  pc_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTR_READ(INSTR_READ), .INSTR_READY(INSTR_READY),
    .INSTR_IN(INSTR_IN), .INSTRUCTION(INSTRUCTION), .JUMP(JUMP), .BRANCH_EQ(BRANCH_EQ),
    .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .OFFSET(OFFSET), .DATA_BUSYWAIT(DATA_BUSYWAIT),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .PC_TARGET(PC_TARGET), .PC_SEL(PC_SEL), .RETIRED(RETIRED)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RESET(RESET), .INSTR_READ(w2_read), .INSTR_READY(INSTR_READY),
    .INSTR_IN(INSTR_IN), .INSTRUCTION(w2_instr), .JUMP(JUMP), .BRANCH_EQ(BRANCH_EQ),
    .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .OFFSET(OFFSET), .DATA_BUSYWAIT(DATA_BUSYWAIT),
    .PC(w2_pc), .PC_PLUS4(w2_plus4), .PC_TARGET(w2_target), .PC_SEL(w2_sel), .RETIRED(w2_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_decode(input logic j, input logic beq, input logic bne,
                            input logic z, input logic [7:0] off);
    JUMP = j; BRANCH_EQ = beq; BRANCH_NE = bne; ZERO = z; OFFSET = off;
  endtask

  task automatic do_reset();
    RESET = 1'b0; INSTR_READY = 1'b1; INSTR_IN = $urandom; DATA_BUSYWAIT = 1'b0;
    tick();
    m_pc = 32'h0; m_ret = 32'h0; m_instr = 32'h0;
    chk("rst_pc", PC, m_pc);
    chk("rst_retired", RETIRED, m_ret);
    chk("rst_instr", INSTRUCTION, m_instr);
    chk("rst_read", 32'(INSTR_READ), 32'd0);
    chk("rst_sel", 32'(PC_SEL), 32'd0);
    RESET = 1'b1; INSTR_IN = $urandom;
    tick();
    chk("idle_exit_read", 32'(INSTR_READ), 32'd1);
    chk("idle_no_capture", INSTRUCTION, 32'h0);
  endtask

  // Run one instruction starting from a FETCH cycle.
  task automatic do_instr(input int waits, input int busy,
                          input logic j, input logic beq, input logic bne, input logic z,
                          input logic [7:0] off, input logic [31:0] word);
    int          start;
    int          o;
    logic        tk;
    logic [31:0] tgt;
    start = cyc;
    chk("f_read", 32'(INSTR_READ), 32'd1);
    chk("f_pc", PC, m_pc);
    chk("f_sel", 32'(PC_SEL), 32'd0);
    chk("f_plus4", PC_PLUS4, m_pc + 32'd4);
    for (int i = 0; i < waits; i++) begin
      INSTR_READY = 1'b0; INSTR_IN = $urandom;
      tick();
      chk("w_read", 32'(INSTR_READ), 32'd1);
      chk("w_instr", INSTRUCTION, m_instr);
      chk("w_pc", PC, m_pc);
    end
    INSTR_READY = 1'b1; INSTR_IN = word;
    tick();
    m_instr = word;
    chk("x_read", 32'(INSTR_READ), 32'd0);
    chk("x_instr", INSTRUCTION, m_instr);
    INSTR_READY = 1'($urandom_range(0, 1)); INSTR_IN = $urandom;
    for (int b = 0; b < busy; b++) begin
      DATA_BUSYWAIT = 1'b1;
      set_decode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
      chk("s_pc", PC, m_pc);
      chk("s_retired", RETIRED, m_ret);
      chk("s_instr", INSTRUCTION, m_instr);
      chk("s_read", 32'(INSTR_READ), 32'd0);
    end
    DATA_BUSYWAIT = 1'b0;
    set_decode(j, beq, bne, z, off);
    #1;
    o   = $signed(off);
    tk  = j | (beq & z) | (bne & ~z);
    tgt = m_pc + 32'd4 + 32'(o * 4);
    chk("x_plus4", PC_PLUS4, m_pc + 32'd4);
    chk("x_target", PC_TARGET, tgt);
    chk("x_sel", 32'(PC_SEL), 32'(tk));
    tick();
    m_pc  = tk ? tgt : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
    chk("n_pc", PC, m_pc);
    chk("n_retired", RETIRED, m_ret);
    chk("n_read", 32'(INSTR_READ), 32'd1);
    chk("latency", 32'(cyc - start), 32'(waits + busy + 2));
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++)
      do_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
  endtask

  initial begin
    int start;
    RESET = 1'b0; INSTR_READY = 1'b0; INSTR_IN = '0; DATA_BUSYWAIT = 1'b0;
    set_decode(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();

    // Sequential flow; second instance starts at the top of the address space.
    do_reset();
    chk("w2_pc_reset", w2_pc, 32'hFFFF_FFFC);
    chk("w2_plus4_wrap", w2_plus4, 32'h0);
    start = cyc;
    seq(1);
    chk("w2_pc_wrapped", w2_pc, 32'h0);
    seq(2);
    chk("three_instr_cycles", 32'(cyc - start), 32'd6);
    chk("three_pc", PC, 32'd12);
    chk("three_retired", RETIRED, 32'd3);

    // Conditional branches at PC 8 and jump at PC 16.
    do_reset();
    seq(2);
    do_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 32'hA000_0001);
    chk("beq_taken_pc", PC, 32'd4);
    seq(1);
    do_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 32'hA000_0002);
    chk("beq_not_taken_pc", PC, 32'd12);
    seq(1);
    do_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 32'hA000_0003);
    chk("jump_pc", PC, 32'd32);
    do_reset();
    seq(4);
    do_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F, 32'hA000_0004);
    chk("bne_pc", PC, 32'd528);
    do_instr(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 32'hA000_0005);
    do_instr(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 32'hA000_0006);

    // Memory wait states on both sides.
    do_instr(3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'hB000_0007);

    // Reset during EXEC at PC 40, then during FETCH with a stale READY.
    do_reset();
    seq(10);
    INSTR_READY = 1'b1; INSTR_IN = 32'hC0DE_0001;
    tick();
    chk("pre_rst_exec_pc", PC, 32'd40);
    RESET = 1'b0; DATA_BUSYWAIT = 1'b1; INSTR_IN = 32'hDEAD_0001;
    tick();
    chk("rst_exec_pc", PC, 32'h0);
    chk("rst_exec_retired", RETIRED, 32'h0);
    chk("rst_exec_read", 32'(INSTR_READ), 32'd0);
    chk("rst_exec_instr", INSTRUCTION, 32'h0);
    RESET = 1'b1; DATA_BUSYWAIT = 1'b0; INSTR_IN = 32'hDEAD_0002;
    tick();
    chk("stale_ready_instr", INSTRUCTION, 32'h0);
    chk("after_rst_read", 32'(INSTR_READ), 32'd1);
    RESET = 1'b0; INSTR_IN = 32'hDEAD_0003;
    tick();
    chk("rst_fetch_read", 32'(INSTR_READ), 32'd0);
    chk("rst_fetch_instr", INSTRUCTION, 32'h0);
    chk("rst_fetch_pc", PC, 32'h0);
    RESET = 1'b1; INSTR_IN = 32'hDEAD_0004;
    tick();
    chk("rst_fetch_stale", INSTRUCTION, 32'h0);
    m_pc = 32'h0; m_ret = 32'h0; m_instr = 32'h0;

    // Negative target below zero, then sequential wrap back to zero.
    do_instr(1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 32'hE000_0001);
    chk("neg_wrap_pc", PC, 32'hFFFF_FFFC);
    seq(1);
    chk("seq_wrap_pc", PC, 32'h0);

    // Random instruction stream.
    for (int k = 0; k < 40; k++)
      do_instr($urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
